// File: rtl/rv32i_dbus_bridge.sv
// rtl/rv32i_dbus_bridge.sv - core data port to Avalon-MM bridge with posted write buffer
// Optional bus watchdog: define RV32I_DBUS_TIMEOUT_EN.
module rv32i_dbus_bridge #(
    parameter int LOG2_WBUF_DEPTH = 2,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] daddress,
    input  logic        dwrite,
    input  logic [31:0] dwritedata,
    input  logic [3:0]  dbyteenable,
    input  logic        dread,
    output logic [31:0] dreaddata,
    output logic        dwaitrequest,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        wbuf_overflow,
    output logic        bus_err
);

    localparam int PW    = LOG2_WBUF_DEPTH;
    localparam int DEPTH = 1 << LOG2_WBUF_DEPTH;

    typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_REQ, RD_DATA, RD_DONE} state_t;

    state_t state, state_next;

    logic [31:0] wb_addr [DEPTH];
    logic [31:0] wb_data [DEPTH];
    logic [3:0]  wb_be   [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [PW:0]   count, avail;

    logic full, push, pop, bus_free, issue_w, start_rd, to_fire;

    assign full        = (count == (PW+1)'(DEPTH));
    assign push        = dwrite & ~full;
    assign pop         = m_write & (~m_waitrequest | to_fire);
    assign avail       = count - (PW+1)'(pop);
    assign rd_ptr_next = rd_ptr + PW'(pop);
    // The bus can take a new beat when idle, or when the current beat completes or is abandoned.
    assign bus_free    = ~(m_read | m_write) | ~m_waitrequest | to_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dread) begin
                    if (count != '0 || m_write || push) state_next = RD_DRAIN;
                    else                                state_next = RD_REQ;
                end
            end
            RD_DRAIN: begin
                if (count == '0 && !m_write && !push) state_next = RD_REQ;
            end
            RD_REQ: begin
                if (to_fire)             state_next = RD_DONE;
                else if (!m_waitrequest) state_next = RD_DATA;
            end
            RD_DATA: begin
                if (m_readdatavalid || to_fire) state_next = RD_DONE;
            end
            RD_DONE:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        dwaitrequest = (dread & (state != RD_DONE)) | (dwrite & full);
        issue_w      = ((state == IDLE) || (state == RD_DRAIN)) && (avail != '0);
        start_rd     = (state_next == RD_REQ) && (state != RD_REQ);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= daddress;
            wb_data[wr_ptr] <= dwritedata;
            wb_be[wr_ptr]   <= dbyteenable;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            wbuf_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_next;
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (dwrite && full) wbuf_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            m_byteenable <= '0;
            dreaddata    <= '0;
        end else begin
            if (bus_free) begin
                m_write <= issue_w;
                m_read  <= start_rd;
                if (issue_w) begin
                    m_address    <= wb_addr[rd_ptr_next];
                    m_writedata  <= wb_data[rd_ptr_next];
                    m_byteenable <= wb_be[rd_ptr_next];
                end else if (start_rd) begin
                    m_address    <= daddress;
                    m_byteenable <= 4'hF;
                end
            end
            if (state == RD_DATA && m_readdatavalid)
                dreaddata <= m_readdata;
            else if (to_fire && (state == RD_REQ || state == RD_DATA))
                dreaddata <= 32'hDEADBEEF;
        end
    end

`ifdef RV32I_DBUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] to_cnt;
    logic            counting;

    assign counting = ((m_read | m_write) & m_waitrequest) | (state == RD_DATA);
    assign to_fire  = counting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= to_fire;
            if (to_fire || (bus_free && (issue_w || start_rd))) to_cnt <= '0;
            else if (counting)                                  to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign to_fire        = 1'b0;
    assign bus_err        = 1'b0;
`endif

endmodule
